placement_out_arbiter: RTL
==========================

Name: placement_out_arbiter

Overview:
Round-robin arbiter that shares the single index-to-output pipeline path between N_REQ program-placement engines. Each engine streams (x, y, strike) placement beats under valid/ready. The arbiter locks the path to one engine until that engine's last beat, so one program's placements are never interleaved with another's. The registered output stage feeds the index/output pipeline register and output_reg.

Parameters:
N_REQ, 4, number of requesting placement engines (2..8)
X_W, 8, x coordinate width
Y_W, 8, y coordinate width
S_W, 4, strike field width
TIMEOUT, 16, idle cycles tolerated from the locked requester before forced release (>=2)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  asynchronous, active-high reset
req_valid  in  N_REQ  per-engine beat valid
req_ready  out  N_REQ  per-engine beat accept
req_last  in  N_REQ  per-engine final beat of a program
req_x  in  N_REQ*X_W  packed x, engine i at [i*X_W +: X_W]
req_y  in  N_REQ*Y_W  packed y, same packing
req_strike  in  N_REQ*S_W  packed strike, same packing
out_valid  out  1  output beat valid
out_ready  in  1  downstream accept
out_x  out  X_W  granted x
out_y  out  Y_W  granted y
out_strike  out  S_W  granted strike
out_id  out  clog2(N_REQ)  source engine of the output beat
out_last  out  1  last beat of the program
busy  out  1  high while in LOCKED
grant_id  out  clog2(N_REQ)  currently or last locked engine
timeout_err  out  1  one-cycle pulse on forced release

Behaviour:
- Reset (async, rst=1): state IDLE; rr pointer 0; grant_id 0; out_valid 0; out_x/out_y/out_strike/out_id/out_last 0; req_ready all 0; busy 0; timeout_err 0; idle counter 0. Takes effect immediately, including mid-transfer. In-flight output beats are discarded.
- FSM has two states:
  - IDLE: req_ready all 0. If any req_valid is high, pick the first asserted index scanning ptr, ptr+1, … mod N_REQ. Register it as grant_id and move to LOCKED next cycle. If none is high, stay in IDLE.
  - LOCKED: busy=1. req_ready[grant_id] = (!out_valid | out_ready). All other ready bits are 0 (combinational from state/out_valid/out_ready only, never from req_valid).
- Transfer: when req_valid[g] & req_ready[g], load the output register with the engine's x/y/strike/last and out_id=g, and set out_valid=1. This supports one beat per cycle under continuous out_ready.
- Output hold: while out_valid & !out_ready, all out_* stay stable. out_valid clears when out_ready is high and no new load occurs that cycle.
- Release on last: a transferred beat with req_last=1 returns to IDLE next cycle and sets ptr=(g+1) mod N_REQ. The minimum gap between programs is 1 arbitration cycle.
- Idle counter: counts only in LOCKED. It increments on cycles where req_valid[g]=0. It clears on any cycle with req_valid[g]=1 or on state change. When it reaches TIMEOUT: go to IDLE, ptr=(g+1) mod N_REQ, and pulse timeout_err for 1 cycle. No out_last is synthesized, and the pending output beat still drains normally.
- Latency: req_valid seen in IDLE at cycle 0 → req_ready high in cycle 1 → out_valid high in cycle 2.
- A requester that drops valid after being sampled in IDLE is still locked; the timeout recovers from this.
- Simultaneous last-beat transfer and timeout threshold: last wins, and timeout_err is not pulsed.
- out_id/grant_id width is max(1, clog2(N_REQ)).

Test Plan:
- Single engine 0, 3 beats (x=1,2,3; y=10,11,12; strike=1,2,3; last on the 3rd), out_ready=1 → out_valid from cycle 2 for 3 consecutive cycles, out_id=0, out_last only on x=3, then busy=0 and ptr=1.
- Engines 0 and 2 both valid from reset with 1-beat programs → grant order 0, 2, 0, 2 (round-robin), each separated by 1 IDLE cycle; no interleaving.
- Engine 1 locked and streaming x=5..8 while engine 3 asserts valid → engine 3 gets no req_ready until engine 1's last beat transfers; engine 3 is then granted.
- Backpressure: out_ready=0 for 4 cycles mid-stream → req_ready[g]=0 after the register fills, out_x stays constant, and no beats are lost or duplicated once out_ready=1.
- Engine 0 locked, valid dropped for TIMEOUT=16 cycles → timeout_err pulses once on the 16th idle cycle, state returns to IDLE, and the next grant goes to a different pending engine.
- Assert rst for 1 cycle mid-burst with out_valid=1 → out_valid and req_ready drop immediately (asynchronous); after release, arbitration restarts from ptr=0.

Source files
------------

// File: rtl/placement_out_arbiter.sv
// Round-robin arbiter sharing one registered output path between N_REQ placement engines.
// A grant is held until the owner's last beat, or until it stays idle for TIMEOUT cycles.
module placement_out_arbiter #(
    parameter int N_REQ   = 4,
    parameter int X_W     = 8,
    parameter int Y_W     = 8,
    parameter int S_W     = 4,
    parameter int TIMEOUT = 16,
    localparam int ID_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [N_REQ-1:0]       req_last,
    input  logic [N_REQ*X_W-1:0]   req_x,
    input  logic [N_REQ*Y_W-1:0]   req_y,
    input  logic [N_REQ*S_W-1:0]   req_strike,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [X_W-1:0]         out_x,
    output logic [Y_W-1:0]         out_y,
    output logic [S_W-1:0]         out_strike,
    output logic [ID_W-1:0]        out_id,
    output logic                   out_last,
    output logic                   busy,
    output logic [ID_W-1:0]        grant_id,
    output logic                   timeout_err
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    // Handshake: a beat moves on a cycle where valid and ready are both high;
    // ready never depends on valid, and the output beat holds while out_valid & !out_ready.
    typedef enum logic {ST_IDLE, ST_LOCKED} state_e;

    state_e            state_q, state_d;
    logic [ID_W-1:0]   ptr_q, ptr_d;
    logic [ID_W-1:0]   grant_q, grant_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              terr_q, terr_d;

    logic              out_valid_q;
    logic [X_W-1:0]    out_x_q;
    logic [Y_W-1:0]    out_y_q;
    logic [S_W-1:0]    out_strike_q;
    logic [ID_W-1:0]   out_id_q;
    logic              out_last_q;

    logic              g_valid, g_last;
    logic [X_W-1:0]    g_x;
    logic [Y_W-1:0]    g_y;
    logic [S_W-1:0]    g_s;
    logic              ready_g, load;
    logic [ID_W-1:0]   next_ptr;

    logic [2*N_REQ-1:0] dbl;
    logic [N_REQ-1:0]   rot;
    logic               pick_found;
    logic [ID_W-1:0]    pick_id;
    int                 off;
    int                 sum;

    always_comb begin
        g_valid = 1'b0;
        g_last  = 1'b0;
        g_x     = '0;
        g_y     = '0;
        g_s     = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_q == ID_W'(i)) begin
                g_valid = req_valid[i];
                g_last  = req_last[i];
                g_x     = req_x[i*X_W +: X_W];
                g_y     = req_y[i*Y_W +: Y_W];
                g_s     = req_strike[i*S_W +: S_W];
            end
        end
    end

    assign ready_g  = !out_valid_q || out_ready;
    assign load     = (state_q == ST_LOCKED) && g_valid && ready_g;
    assign next_ptr = (grant_q == ID_W'(N_REQ - 1)) ? '0 : grant_q + 1'b1;

    always_comb begin
        req_ready = '0;
        if (state_q == ST_LOCKED) begin
            req_ready[grant_q] = ready_g;
        end
    end

    // Rotate the requests so bit 0 is the pointer position, then take the lowest set bit.
    always_comb begin
        dbl        = {req_valid, req_valid} >> ptr_q;
        rot        = dbl[N_REQ-1:0];
        pick_found = 1'b0;
        off        = 0;
        for (int j = N_REQ - 1; j >= 0; j--) begin
            if (rot[j]) begin
                pick_found = 1'b1;
                off        = j;
            end
        end
        sum = int'(ptr_q) + off;
        if (sum >= N_REQ) begin
            sum = sum - N_REQ;
        end
        pick_id = ID_W'(sum);
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        cnt_d   = cnt_q;
        terr_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (pick_found) begin
                    grant_d = pick_id;
                    state_d = ST_LOCKED;
                end
            end
            ST_LOCKED: begin
                if (load && g_last) begin
                    state_d = ST_IDLE;
                    ptr_d   = next_ptr;
                    cnt_d   = '0;
                end else if (!g_valid) begin
                    if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                        state_d = ST_IDLE;
                        ptr_d   = next_ptr;
                        cnt_d   = '0;
                        terr_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else begin
                    cnt_d = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            grant_q <= '0;
            cnt_q   <= '0;
            terr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            cnt_q   <= cnt_d;
            terr_q  <= terr_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            out_x_q      <= '0;
            out_y_q      <= '0;
            out_strike_q <= '0;
            out_id_q     <= '0;
            out_last_q   <= 1'b0;
        end else if (load) begin
            out_valid_q  <= 1'b1;
            out_x_q      <= g_x;
            out_y_q      <= g_y;
            out_strike_q <= g_s;
            out_id_q     <= grant_q;
            out_last_q   <= g_last;
        end else if (out_ready) begin
            out_valid_q  <= 1'b0;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_x       = out_x_q;
    assign out_y       = out_y_q;
    assign out_strike  = out_strike_q;
    assign out_id      = out_id_q;
    assign out_last    = out_last_q;
    assign busy        = (state_q == ST_LOCKED);
    assign grant_id    = grant_q;
    assign timeout_err = terr_q;

endmodule
